// File: rtl/issue_tx.sv
`default_nettype none
// ============================================================================
// Module   : issue_tx
// Brief    : FIFO-buffered two-phase (toggle) instruction transmitter for the
//            issue-stage channel, with handshake timeout/protocol flags.
// Revision : 1.0
// ============================================================================
module issue_tx #(
   parameter int DEPTH        = 4,
   parameter int SETUP_CYCLES = 1,
   parameter int TIMEOUT      = 1024
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        wrValid,
   input  logic [31:0] wrData,
   output logic        wrReady,
   output logic        readyOut,
   output logic [31:0] dataOut,
   output logic        triggerOut,
   input  logic        ackIn,
   output logic        timeoutErr,
   output logic        protoErr,
   output logic [15:0] issuedCount
);

   localparam int c_PTR_W = $clog2(DEPTH);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_SETUP    = 2'd1;
   localparam logic [1:0] c_WAIT_ACK = 2'd2;
   localparam logic [1:0] c_GAP      = 2'd3;

   localparam logic [c_PTR_W:0]   c_DEPTH      = (c_PTR_W + 1)'(DEPTH);
   localparam logic [c_PTR_W:0]   c_CNT_ONE    = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);
   localparam logic [3:0]         c_SETUP_LOAD = 4'(SETUP_CYCLES);
   localparam logic [15:0]        c_TIMEOUT    = 16'(TIMEOUT);

   logic [31:0]        r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wrPtr;
   logic [c_PTR_W-1:0] r_rdPtr;
   logic [c_PTR_W:0]   r_count;
   logic [1:0]         r_state;
   logic [3:0]         r_setupCnt;
   logic [15:0]        r_toCnt;
   logic               r_ackMeta;
   logic               r_ackSync;
   logic               r_ackSeen;

   logic        w_push;
   logic        w_pop;
   logic        w_ackEvent;
   logic [15:0] w_toNext;

   assign wrReady    = (r_count != c_DEPTH);
   assign w_push     = wrValid && wrReady;
   assign w_ackEvent = (r_ackSync != r_ackSeen);
   assign w_pop      = (r_state == c_WAIT_ACK) && w_ackEvent;
   assign w_toNext   = (r_toCnt == c_TIMEOUT) ? r_toCnt : r_toCnt + 16'd1;

   // Storage carries no reset; occupancy is tracked solely by r_count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= wrData;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
         if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // ackIn is asynchronous; either edge of the synchronised level is one ack.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_ackMeta <= 1'b0;
         r_ackSync <= 1'b0;
         r_ackSeen <= 1'b0;
      end else begin
         r_ackMeta <= ackIn;
         r_ackSync <= r_ackMeta;
         if (w_ackEvent) r_ackSeen <= r_ackSync;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= c_IDLE;
         r_setupCnt  <= '0;
         r_toCnt     <= '0;
         readyOut    <= 1'b0;
         dataOut     <= '0;
         triggerOut  <= 1'b0;
         timeoutErr  <= 1'b0;
         protoErr    <= 1'b0;
         issuedCount <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (r_count != '0) begin
                  dataOut    <= r_mem[r_rdPtr];
                  readyOut   <= 1'b1;
                  r_setupCnt <= c_SETUP_LOAD;
                  r_state    <= c_SETUP;
               end
            end
            c_SETUP: begin
               // Toggle on the edge where the countdown reaches zero.
               if (r_setupCnt <= 4'd1) begin
                  r_setupCnt <= '0;
                  triggerOut <= ~triggerOut;
                  r_toCnt    <= '0;
                  r_state    <= c_WAIT_ACK;
               end else begin
                  r_setupCnt <= r_setupCnt - 4'd1;
               end
            end
            c_WAIT_ACK: begin
               if (w_ackEvent) begin
                  readyOut    <= 1'b0;
                  issuedCount <= issuedCount + 16'd1;
                  r_state     <= c_GAP;
               end else begin
                  r_toCnt <= w_toNext;
                  if (w_toNext == c_TIMEOUT) timeoutErr <= 1'b1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
         if (w_ackEvent && (r_state != c_WAIT_ACK)) protoErr <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_issue_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_tx
// Brief    : Directed vector table plus multi-cycle sequences for issue_tx.
// Revision : 1.0
// ============================================================================
module tb_issue_tx;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        wrValid = 1'b0;
   logic [31:0] wrData = '0;
   logic        ackIn = 1'b0;
   logic        wrReady;
   logic        readyOut;
   logic [31:0] dataOut;
   logic        triggerOut;
   logic        timeoutErr;
   logic        protoErr;
   logic [15:0] issuedCount;

   int nCompared = 0;
   int nFailed   = 0;

   issue_tx #(
      .DEPTH(4),
      .SETUP_CYCLES(1),
      .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .wrValid(wrValid),
      .wrData(wrData),
      .wrReady(wrReady),
      .readyOut(readyOut),
      .dataOut(dataOut),
      .triggerOut(triggerOut),
      .ackIn(ackIn),
      .timeoutErr(timeoutErr),
      .protoErr(protoErr),
      .issuedCount(issuedCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wrValid;
      logic [31:0] wrData;
      logic        ackIn;
      logic        expReady;
      logic [31:0] expData;
      logic        expTrig;
      logic        expWrReady;
      logic [15:0] expIssued;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic getSig(input int sel);
      case (sel)
         0:       return readyOut;
         1:       return triggerOut;
         default: return wrReady;
      endcase
   endfunction

   // sel: 0 readyOut, 1 triggerOut, 2 wrReady
   task automatic waitFor(input string name, input int sel, input logic val, input int budget);
      for (int i = 0; i < budget && getSig(sel) !== val; i++) tick();
      check(name, 32'(getSig(sel)), 32'(val));
   endtask

   task automatic applyReset();
      wrValid = 1'b0;
      ackIn   = 1'b0;
      resetN  = 1'b0;
      tick();
      tick();
      resetN = 1'b1;
      tick();
   endtask

   task automatic sendWord(input logic [31:0] w);
      wrValid = 1'b1;
      wrData  = w;
      tick();
      wrValid = 1'b0;
   endtask

   logic [31:0] words[5];
   logic        phase;

   initial begin
      // {wrValid, wrData, ackIn, expReady, expData, expTrig, expWrReady, expIssued}
      vecs[0]  = '{1'b1, 32'h00FF00FF, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 16'd0};
      vecs[1]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00FF00FF, 1'b0, 1'b1, 16'd0};
      vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h00FF00FF, 1'b1, 1'b1, 16'd0};
      vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00FF00FF, 1'b1, 1'b1, 16'd0};
      vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00FF00FF, 1'b1, 1'b1, 16'd0};
      vecs[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00FF00FF, 1'b1, 1'b1, 16'd1};
      vecs[6]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 32'h00FF00FF, 1'b1, 1'b1, 16'd1};
      vecs[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 16'd1};
      vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, 16'd1};
      vecs[9]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 16'd1};
      vecs[10] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, 16'd1};
      vecs[11] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1, 16'd2};

      words[0] = 32'h80FF00FF;
      words[1] = 32'h80F0F0F0;
      words[2] = 32'h10FF00FF;
      words[3] = 32'hE0FF00FF;
      words[4] = 32'h5A5A0001;

      // Reset state
      tick();
      tick();
      check("rst readyOut", 32'(readyOut), 32'd0);
      check("rst dataOut", dataOut, 32'd0);
      check("rst triggerOut", 32'(triggerOut), 32'd0);
      check("rst wrReady", 32'(wrReady), 32'd1);
      check("rst issuedCount", 32'(issuedCount), 32'd0);
      check("rst errors", {30'd0, timeoutErr, protoErr}, 32'd0);
      resetN = 1'b1;

      // Two single-word handshakes, cycle by cycle
      for (int i = 0; i < 12; i++) begin
         wrValid = vecs[i].wrValid;
         wrData  = vecs[i].wrData;
         ackIn   = vecs[i].ackIn;
         tick();
         check($sformatf("vec%0d readyOut", i), 32'(readyOut), 32'(vecs[i].expReady));
         check($sformatf("vec%0d dataOut", i), dataOut, vecs[i].expData);
         check($sformatf("vec%0d triggerOut", i), 32'(triggerOut), 32'(vecs[i].expTrig));
         check($sformatf("vec%0d wrReady", i), 32'(wrReady), 32'(vecs[i].expWrReady));
         check($sformatf("vec%0d issuedCount", i), 32'(issuedCount), 32'(vecs[i].expIssued));
         check($sformatf("vec%0d errors", i), {30'd0, timeoutErr, protoErr}, 32'd0);
      end
      wrValid = 1'b0;

      // Fill to full, then push a fifth word as the first pop frees a slot
      applyReset();
      for (int k = 0; k < 4; k++) begin
         wrValid = 1'b1;
         wrData  = words[k];
         tick();
      end
      check("fill wrReady full", 32'(wrReady), 32'd0);
      wrData = words[4];
      waitFor("fill trig w0", 1, 1'b1, 4);
      check("fill ready w0", 32'(readyOut), 32'd1);
      check("fill data w0", dataOut, words[0]);
      ackIn = ~ackIn;
      waitFor("pushpop wrReady reassert", 2, 1'b1, 6);
      check("pushpop issued after w0", 32'(issuedCount), 32'd1);
      check("pushpop ready low", 32'(readyOut), 32'd0);
      tick();
      wrValid = 1'b0;
      check("pushpop full again", 32'(wrReady), 32'd0);
      phase = 1'b1;
      for (int k = 1; k < 5; k++) begin
         phase = ~phase;
         waitFor($sformatf("drain trig w%0d", k), 1, phase, 8);
         check($sformatf("drain ready w%0d", k), 32'(readyOut), 32'd1);
         check($sformatf("drain data w%0d", k), dataOut, words[k]);
         ackIn = ~ackIn;
         waitFor($sformatf("drain release w%0d", k), 0, 1'b0, 5);
         check($sformatf("drain issued w%0d", k), 32'(issuedCount), 32'(k + 1));
      end
      check("drain empty", 32'(wrReady), 32'd1);
      check("drain errors", {30'd0, timeoutErr, protoErr}, 32'd0);

      // Timeout exactly TIMEOUT cycles after the trigger, then a late ack
      applyReset();
      sendWord(32'hDEADBEEF);
      waitFor("to trig", 1, 1'b1, 4);
      repeat (7) tick();
      check("to not yet", 32'(timeoutErr), 32'd0);
      tick();
      check("to set", 32'(timeoutErr), 32'd1);
      check("to ready held", 32'(readyOut), 32'd1);
      ackIn = ~ackIn;
      waitFor("to late ack release", 0, 1'b0, 5);
      check("to issued", 32'(issuedCount), 32'd1);
      check("to sticky", 32'(timeoutErr), 32'd1);
      check("to no proto", 32'(protoErr), 32'd0);

      // Spurious ack while idle and empty
      applyReset();
      ackIn = 1'b1;
      repeat (3) tick();
      check("spur protoErr", 32'(protoErr), 32'd1);
      check("spur issued", 32'(issuedCount), 32'd0);
      check("spur ready", 32'(readyOut), 32'd0);
      check("spur wrReady", 32'(wrReady), 32'd1);
      sendWord(32'hCAFE0123);
      waitFor("spur trig", 1, 1'b1, 4);
      check("spur data", dataOut, 32'hCAFE0123);
      ackIn = 1'b0;
      waitFor("spur release", 0, 1'b0, 5);
      check("spur issued after", 32'(issuedCount), 32'd1);

      // Reset in WAIT_ACK with two more words queued
      applyReset();
      for (int k = 0; k < 3; k++) begin
         wrValid = 1'b1;
         wrData  = words[k];
         tick();
      end
      wrValid = 1'b0;
      waitFor("mid trig", 1, 1'b1, 4);
      resetN = 1'b0;
      ackIn  = 1'b0;
      #1;
      check("mid rst readyOut", 32'(readyOut), 32'd0);
      check("mid rst dataOut", dataOut, 32'd0);
      check("mid rst triggerOut", 32'(triggerOut), 32'd0);
      check("mid rst wrReady", 32'(wrReady), 32'd1);
      check("mid rst issued", 32'(issuedCount), 32'd0);
      tick();
      tick();
      resetN = 1'b1;
      repeat (3) tick();
      check("mid post idle", 32'(readyOut), 32'd0);
      check("mid post empty", 32'(wrReady), 32'd1);
      sendWord(32'h11112222);
      tick();
      check("mid new ready", 32'(readyOut), 32'd1);
      check("mid new data", dataOut, 32'h11112222);
      check("mid new trig phase", 32'(triggerOut), 32'd0);
      waitFor("mid new trig", 1, 1'b1, 3);
      ackIn = 1'b1;
      waitFor("mid new release", 0, 1'b0, 5);
      check("mid new issued", 32'(issuedCount), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
